dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, memory word-address bits driven to the data memory.
REQ-002 SHALL have parameter DATA_WIDTH, default OPERAND_WIDTH (32), data path width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports c_req/d_req  input  1  core (MEM stage) / DMA access request.
REQ-006 SHALL have ports c_we/d_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have ports c_addr/d_addr  input  DATA_WIDTH  byte address; only bits [ADDR_WIDTH-1:0] are used.
REQ-008 SHALL have ports c_wdata/d_wdata  input  DATA_WIDTH  store data.
REQ-009 SHALL have ports c_size/d_size  input  3  word-size code (000 b, 001 h, 010 w, 100 bu, 101 hu).
REQ-010 SHALL have ports c_gnt/d_gnt  output  1  request accepted this cycle.
REQ-011 SHALL have ports c_rvalid/d_rvalid  output  1  load data valid, one-cycle pulse.
REQ-012 SHALL have port rdata  output  DATA_WIDTH  load data, shared by both requesters and qualified by the owner's rvalid.
REQ-013 SHALL have ports mem_we (1), mem_addr (ADDR_WIDTH), mem_wdata (DATA_WIDTH) and mem_size (3), all outputs to the data memory.
REQ-014 SHALL have port mem_rdata  input  DATA_WIDTH  memory read data, valid the cycle after the address is presented.

Function
REQ-015 SHALL implement a state machine with states IDLE and RD_WAIT.
REQ-016 IDLE: SHALL arbitrate among asserted requests and assert exactly one gnt combinationally in the same cycle; the granted requester's addr/wdata/size SHALL drive the mem_* outputs.
REQ-017 A granted store SHALL assert mem_we in the grant cycle, complete in that cycle, and leave the state in IDLE.
REQ-018 A granted load SHALL hold mem_we at 0, register the owner, and go to RD_WAIT.
REQ-019 RD_WAIT: SHALL capture mem_rdata into rdata and pulse the owner's rvalid for one cycle, assert no gnt, and return to IDLE; load-to-load throughput is therefore one per 2 cycles.
REQ-020 A requester that drops req while in RD_WAIT SHALL still receive its rvalid.
REQ-021 When no gnt is asserted, mem_we SHALL be 0; mem_addr, mem_wdata and mem_size SHALL hold the core's values.
REQ-022 Both gnt outputs SHALL never be high together, and the two rvalid outputs SHALL never be high together.
REQ-023 mem_size SHALL pass through unchanged; lane shifting and sign extension are outside this block.
REQ-024 A request with req held low SHALL have no effect; a gnt SHALL never be issued without the matching req.

Reset
REQ-025 On rst low, SHALL go to IDLE asynchronously, with c_gnt, d_gnt, c_rvalid, d_rvalid and mem_we at 0, rdata at 0 and last_owner = DMA.
REQ-026 Reset during RD_WAIT SHALL abort the pending load, and no rvalid SHALL follow the reset release.
REQ-027 The first active edge after release SHALL arbitrate normally.

Configuration
REQ-028 With DMEM_ARB_ROUND_ROBIN_EN defined: on simultaneous requests, SHALL grant the requester not granted last; last_owner SHALL update on every grant.
REQ-029 Without DMEM_ARB_ROUND_ROBIN_EN: the core SHALL always win, the DMA SHALL be granted only when c_req is low, and the last_owner register SHALL not be built.

Structure
REQ-030 The state enum (IDLE, RD_WAIT), the owner enum (CORE, DMA) and the size codes SHALL live in package common; OPERAND_WIDTH SHALL come from common.
REQ-031 SHALL use one sub-module, dmem_arb_pick: a combinational grant selector with inputs c_req, d_req, last_owner and idle, and outputs the one-hot gnt.

Verification
REQ-032 Core store only: c_req=1, c_we=1, c_addr=0x10, c_wdata=0xDEADBEEF -> c_gnt=1, mem_we=1 and mem_addr=0x10 in the same cycle, state stays IDLE.
REQ-033 DMA load: d_req=1, d_we=0, d_addr=0x20 with mem_rdata=0x12345678 -> d_gnt in cycle 0, then d_rvalid=1 and rdata=0x12345678 in cycle 1, with c_gnt=0 throughout.
REQ-034 Both requesting continuously for 6 cycles with stores -> round-robin build: gnt alternates core, DMA, core...; fixed-priority build: c_gnt every cycle and d_gnt never.
REQ-035 Core load, c_req dropped during RD_WAIT -> c_rvalid still pulses once; a d_req pending in RD_WAIT gets d_gnt only in the following cycle.
REQ-036 rst asserted in RD_WAIT -> rvalid=0 and mem_we=0 immediately; no rvalid after release; the next request is granted on the first edge.

Source files
------------

// File: rtl/common.sv
// Shared types for the data-memory arbiter: FSM states, owners, size codes.
package common;

    localparam int OPERAND_WIDTH = 32;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } arb_state_t;

    typedef enum logic {
        CORE = 1'b0,
        DMA  = 1'b1
    } owner_t;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational grant selector for the data-memory arbiter.
// DMEM_ARB_ROUND_ROBIN_EN selects round-robin instead of core-first priority.
module dmem_arb_pick
    import common::*;
(
    input  logic       c_req,
    input  logic       d_req,
    input  owner_t     last_owner,
    input  logic       idle,
    output logic [1:0] gnt
);

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        gnt = 2'b00;
        if (idle) begin
            if (c_req && d_req)
                gnt = (last_owner == DMA) ? 2'b01 : 2'b10;
            else
                gnt = {d_req, c_req};
        end
    end
`else
    logic unused_last;
    assign unused_last = last_owner;

    always_comb begin
        gnt = 2'b00;
        if (idle) begin
            if (c_req)
                gnt = 2'b01;
            else if (d_req)
                gnt = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester (core/DMA) data-memory arbiter with a one-cycle load wait.
// DMEM_ARB_ROUND_ROBIN_EN builds the last_owner register for round-robin.
module dmem_arbiter
    import common::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = OPERAND_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  c_req,
    input  logic                  d_req,
    input  logic                  c_we,
    input  logic                  d_we,
    input  logic [DATA_WIDTH-1:0] c_addr,
    input  logic [DATA_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] c_wdata,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [2:0]            c_size,
    input  logic [2:0]            d_size,
    output logic                  c_gnt,
    output logic                  d_gnt,
    output logic                  c_rvalid,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [2:0]            mem_size,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    arb_state_t            state_q;
    arb_state_t            state_d;
    owner_t                owner_q;
    owner_t                last_owner;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            gnt;
    logic                  idle;
    logic                  load_start;
    logic                  unused_addr;

    assign unused_addr = ^{c_addr[DATA_WIDTH-1:ADDR_WIDTH],
                           d_addr[DATA_WIDTH-1:ADDR_WIDTH]};

    // gating with rst keeps grants silent while reset is held
    assign idle = rst && (state_q == IDLE);

    dmem_arb_pick u_pick (
        .c_req      (c_req),
        .d_req      (d_req),
        .last_owner (last_owner),
        .idle       (idle),
        .gnt        (gnt)
    );

    assign c_gnt = gnt[0];
    assign d_gnt = gnt[1];

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = c_addr[ADDR_WIDTH-1:0];
        mem_wdata = c_wdata;
        mem_size  = c_size;
        if (d_gnt) begin
            mem_we    = d_we;
            mem_addr  = d_addr[ADDR_WIDTH-1:0];
            mem_wdata = d_wdata;
            mem_size  = d_size;
        end else if (c_gnt) begin
            mem_we = c_we;
        end
    end

    assign load_start = (c_gnt && !c_we) || (d_gnt && !d_we);

    always_comb begin
        state_d  = state_q;
        c_rvalid = 1'b0;
        d_rvalid = 1'b0;
        rdata    = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (load_start)
                    state_d = RD_WAIT;
            end
            RD_WAIT: begin
                c_rvalid = (owner_q == CORE);
                d_rvalid = (owner_q == DMA);
                rdata    = mem_rdata;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= CORE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (load_start)
                owner_q <= d_gnt ? DMA : CORE;
            if (state_q == RD_WAIT)
                rdata_q <= mem_rdata;
        end
    end

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            last_owner <= DMA;
        else if (c_gnt || d_gnt)
            last_owner <= d_gnt ? DMA : CORE;
    end
`else
    assign last_owner = DMA;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter against a transaction-level model.
module tb_dmem_arbiter;
    import common::*;

    localparam int AW = 8;
    localparam int DW = 32;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          c_req, d_req, c_we, d_we;
    logic [DW-1:0] c_addr, d_addr, c_wdata, d_wdata;
    logic [2:0]    c_size, d_size;
    logic          c_gnt, d_gnt, c_rvalid, d_rvalid;
    logic [DW-1:0] rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [2:0]    mem_size;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .c_req     (c_req),
        .d_req     (d_req),
        .c_we      (c_we),
        .d_we      (d_we),
        .c_addr    (c_addr),
        .d_addr    (d_addr),
        .c_wdata   (c_wdata),
        .d_wdata   (d_wdata),
        .c_size    (c_size),
        .d_size    (d_size),
        .c_gnt     (c_gnt),
        .d_gnt     (d_gnt),
        .c_rvalid  (c_rvalid),
        .d_rvalid  (d_rvalid),
        .rdata     (rdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_size  (mem_size),
        .mem_rdata (mem_rdata)
    );

    // synchronous-read memory; starts all zero
    logic [DW-1:0] mem_q [256];
    always @(posedge clk) begin
        if (mem_we)
            mem_q[mem_addr] <= mem_wdata;
        mem_rdata <= mem_q[mem_addr];
    end

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: memory contents and transaction bookkeeping
    logic [DW-1:0] shadow [256];
    bit            busy;
    bit            pend_dma;
    logic [DW-1:0] pend_val;
    bit            last_dma;

    logic [2:0] sizes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        busy     = 1'b0;
        pend_dma = 1'b0;
        last_dma = 1'b1;
    endtask

    task automatic check_cycle();
        bit cw;
        bit dw;
        logic [7:0] a;
        if (busy) begin
            chk("busy c_gnt", c_gnt, 0);
            chk("busy d_gnt", d_gnt, 0);
            chk("c_rvalid", c_rvalid, !pend_dma);
            chk("d_rvalid", d_rvalid, pend_dma);
            chk("rdata", rdata, pend_val);
            chk("busy mem_we", mem_we, 0);
            chk("busy mem_addr", mem_addr, c_addr[7:0]);
            busy = 1'b0;
        end else begin
            cw = c_req && (!d_req || !RR || last_dma);
            dw = d_req && !cw;
            chk("c_gnt", c_gnt, cw);
            chk("d_gnt", d_gnt, dw);
            chk("idle c_rvalid", c_rvalid, 0);
            chk("idle d_rvalid", d_rvalid, 0);
            chk("mem_we", mem_we, dw ? d_we : (cw && c_we));
            chk("mem_addr", mem_addr, dw ? d_addr[7:0] : c_addr[7:0]);
            chk("mem_wdata", mem_wdata, dw ? d_wdata : c_wdata);
            chk("mem_size", mem_size, dw ? d_size : c_size);
            if (cw || dw) begin
                last_dma = dw;
                a = dw ? d_addr[7:0] : c_addr[7:0];
                if (dw ? d_we : c_we) begin
                    shadow[a] = dw ? d_wdata : c_wdata;
                end else begin
                    busy     = 1'b1;
                    pend_dma = dw;
                    pend_val = shadow[a];
                end
            end
        end
    endtask

    // inputs are set at posedge+1; check mid-cycle, then advance
    task automatic step();
        #3;
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit cr, input bit cwe, input logic [31:0] ca,
                         input logic [31:0] cd, input bit dr, input bit dwe,
                         input logic [31:0] da, input logic [31:0] dd);
        c_req   = cr;
        c_we    = cwe;
        c_addr  = ca;
        c_wdata = cd;
        c_size  = sizes[$urandom_range(0, 4)];
        d_req   = dr;
        d_we    = dwe;
        d_addr  = da;
        d_wdata = dd;
        d_size  = sizes[$urandom_range(0, 4)];
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_q[i]  = '0;
            shadow[i] = '0;
        end
        pend_val = '0;
        model_reset();
        rst = 1'b0;
        drive(1, 1, 32'h10, 32'h1, 1, 1, 32'h20, 32'h2);
        #2;
        chk("rst c_gnt", c_gnt, 0);
        chk("rst d_gnt", d_gnt, 0);
        chk("rst c_rvalid", c_rvalid, 0);
        chk("rst d_rvalid", d_rvalid, 0);
        chk("rst mem_we", mem_we, 0);
        chk("rst rdata", rdata, 0);
        #10;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        // core store, then a value for the DMA to load back
        drive(1, 1, 32'hFFFF_FF10, 32'hDEADBEEF, 0, 0, 0, 0);
        step();
        drive(1, 1, 32'h20, 32'h12345678, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 1, 0, 32'h20, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        chk("dma load rdata", rdata, 32'h12345678);
        chk("dma load d_rvalid", d_rvalid, 1);
        #1;
        step();

        // contention with stores
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, i, $urandom, 1, 1, 32'h40 + i, $urandom);
            step();
        end

        // core load; core drops req in RD_WAIT while DMA waits
        drive(1, 0, 32'h10, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 1, 1, 32'h30, 32'hA5A5_5A5A);
        step();
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();

        // reset during RD_WAIT
        drive(1, 0, 32'h20, 0, 0, 0, 0, 0);
        step();
        drive(1, 1, 32'h50, 32'h5555_AAAA, 0, 0, 0, 0);
        #1;
        rst = 1'b0;
        #1;
        chk("abort c_rvalid", c_rvalid, 0);
        chk("abort d_rvalid", d_rvalid, 0);
        chk("abort mem_we", mem_we, 0);
        chk("abort c_gnt", c_gnt, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();

        for (int i = 0; i < 500; i++) begin
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  {$urandom_range(0, 255), 4'h0, 4'($urandom_range(0, 15))},
                  $urandom,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  {$urandom_range(0, 255), 4'h0, 4'($urandom_range(0, 15))},
                  $urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
